// File: rtl/multi_sync_debounce.sv
// ============================================================================
//  Module   : multi_sync_debounce
//  Purpose  : Per-channel N-flop synchroniser, stability-count debouncer and
//             registered rise/fall event pulses for asynchronous inputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_sync_debounce #(
    parameter int   CHANNELS  = 4,
    parameter int   STAGES    = 2,
    parameter int   DB_CYCLES = 16,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] async_in,
    input  logic                db_bypass,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_change
);

    localparam int             CNT_W   = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic any_change_q;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            logic [STAGES-1:0] sync_q;
            logic              synced;
            logic [CNT_W-1:0]  cnt_q, cnt_d;
            logic              level_q, level_d;
            logic              rise_q, fall_q;

            assign synced = sync_q[STAGES-1];

            always_comb begin
                cnt_d   = '0;
                level_d = level_q;
                if (db_bypass) begin
                    level_d = synced;
                end else if (synced != level_q) begin
                    // Accept only after DB_CYCLES consecutive disagreeing samples
                    if (cnt_q == CNT_MAX) begin
                        level_d = synced;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q  <= {STAGES{RESET_VAL}};
                    cnt_q   <= '0;
                    level_q <= RESET_VAL;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    sync_q  <= {sync_q[STAGES-2:0], async_in[i]};
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                    rise_q  <= level_d & ~level_q;
                    fall_q  <= ~level_d & level_q;
                end
            end

            assign level_out[i]  = level_q;
            assign rise_pulse[i] = rise_q;
            assign fall_pulse[i] = fall_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= |(rise_pulse | fall_pulse);
        end
    end

    assign any_change = any_change_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_sync_debounce.sv
// ============================================================================
//  Module   : tb_multi_sync_debounce
//  Purpose  : Directed self-checking bench for multi_sync_debounce.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_sync_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] async_in;
    logic       db_bypass;
    logic [3:0] level_out, rise_pulse, fall_pulse;
    logic       any_change;

    logic [0:0] a1;
    logic [0:0] lvl1, rise1, fall1;
    logic       any1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_sync_debounce #(
        .CHANNELS (4),
        .STAGES   (2),
        .DB_CYCLES(16),
        .RESET_VAL(1'b0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .async_in  (async_in),
        .db_bypass (db_bypass),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_change(any_change)
    );

    multi_sync_debounce #(
        .CHANNELS (1),
        .STAGES   (3),
        .DB_CYCLES(1),
        .RESET_VAL(1'b0)
    ) u_dut_sweep (
        .clk       (clk),
        .rst       (rst),
        .async_in  (a1),
        .db_bypass (1'b0),
        .level_out (lvl1),
        .rise_pulse(rise1),
        .fall_pulse(fall1),
        .any_change(any1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int  nrise;
        logic bad;

        rst       = 1'b1;
        async_in  = 4'b0000;
        db_bypass = 1'b0;
        a1        = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset_level", level_out, 4'b0000);
        chk("reset_rise",  rise_pulse, 4'b0000);
        chk("reset_fall",  fall_pulse, 4'b0000);
        chk("reset_any",   any_change, 1'b0);

        // Clean press and release on channel 0
        async_in[0] = 1'b1;
        tick(17);
        chk("press_e17_level", level_out[0], 1'b0);
        tick(1);
        chk("press_e18_level", level_out[0], 1'b1);
        chk("press_e18_rise",  rise_pulse, 4'b0001);
        chk("press_e18_any",   any_change, 1'b0);
        tick(1);
        chk("press_e19_rise",  rise_pulse, 4'b0000);
        chk("press_e19_any",   any_change, 1'b1);
        tick(1);
        chk("press_e20_any",   any_change, 1'b0);
        async_in[0] = 1'b0;
        tick(17);
        chk("release_e17_level", level_out[0], 1'b1);
        tick(1);
        chk("release_e18_level", level_out[0], 1'b0);
        chk("release_e18_fall",  fall_pulse, 4'b0001);
        tick(1);
        chk("release_e19_fall",  fall_pulse, 4'b0000);

        // Bounce rejection on channel 1
        bad = 1'b0;
        repeat (4) begin
            async_in[1] = 1'b1;
            repeat (5) begin
                tick(1);
                bad = bad | level_out[1] | rise_pulse[1] | fall_pulse[1];
            end
            async_in[1] = 1'b0;
            tick(1);
            bad = bad | level_out[1] | rise_pulse[1] | fall_pulse[1];
        end
        chk("bounce_rejected", bad, 1'b0);
        async_in[1] = 1'b1;
        nrise = 0;
        repeat (25) begin
            tick(1);
            if (rise_pulse[1]) nrise++;
        end
        chk("bounce_hold_rises", nrise, 1);
        chk("bounce_hold_level", level_out[1], 1'b1);
        async_in[1] = 1'b0;
        tick(20);
        chk("bounce_settle_level", level_out, 4'b0000);

        // Simultaneous channels
        async_in = 4'b1011;
        tick(17);
        chk("simul_e17_rise", rise_pulse, 4'b0000);
        tick(1);
        chk("simul_e18_rise",  rise_pulse, 4'b1011);
        chk("simul_e18_level", level_out,  4'b1011);
        tick(1);
        chk("simul_e19_rise", rise_pulse, 4'b0000);
        chk("simul_e19_any",  any_change, 1'b1);
        tick(1);
        chk("simul_e20_any",  any_change, 1'b0);
        async_in = 4'b0000;
        tick(18);
        chk("simul_fall", fall_pulse, 4'b1011);
        tick(2);

        // Bypass: one-cycle high on channel 2
        db_bypass   = 1'b1;
        async_in[2] = 1'b1;
        tick(1);
        async_in[2] = 1'b0;
        tick(1);
        chk("byp_e2_level", level_out[2], 1'b0);
        tick(1);
        chk("byp_e3_level", level_out[2], 1'b1);
        chk("byp_e3_rise",  rise_pulse, 4'b0100);
        tick(1);
        chk("byp_e4_level", level_out[2], 1'b0);
        chk("byp_e4_fall",  fall_pulse, 4'b0100);
        chk("byp_e4_rise",  rise_pulse, 4'b0000);
        chk("byp_e4_any",   any_change, 1'b1);
        tick(1);
        chk("byp_e5_fall",  fall_pulse, 4'b0000);
        chk("byp_e5_any",   any_change, 1'b1);
        tick(1);
        chk("byp_e6_any",   any_change, 1'b0);

        // Bypass entered mid-count takes synced on the next edge
        db_bypass   = 1'b0;
        async_in[2] = 1'b1;
        tick(8);
        chk("midcnt_level_before", level_out[2], 1'b0);
        db_bypass = 1'b1;
        tick(1);
        chk("midcnt_bypass_level", level_out[2], 1'b1);
        chk("midcnt_bypass_rise",  rise_pulse, 4'b0100);
        // Leaving bypass restarts the count from zero
        db_bypass   = 1'b0;
        async_in[2] = 1'b0;
        tick(17);
        chk("restart_e17_level", level_out[2], 1'b1);
        tick(1);
        chk("restart_e18_level", level_out[2], 1'b0);
        chk("restart_e18_fall",  fall_pulse, 4'b0100);
        tick(2);

        // Asynchronous reset mid-count clears without a clock edge
        async_in[0] = 1'b1;
        tick(25);
        async_in[3] = 1'b1;
        tick(5);
        chk("prereset_level", level_out, 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_level", level_out, 4'b0000);
        chk("async_rst_any",   any_change, 1'b0);
        async_in = 4'b0000;
        tick(2);
        rst = 1'b0;
        tick(20);
        chk("postreset_level", level_out, 4'b0000);

        // Sweep instance: STAGES=3, DB_CYCLES=1
        a1 = 1'b1;
        tick(3);
        chk("sweep_e3_level", lvl1, 1'b0);
        tick(1);
        chk("sweep_e4_level", lvl1, 1'b1);
        chk("sweep_e4_rise",  rise1, 1'b1);
        tick(1);
        chk("sweep_e5_rise",  rise1, 1'b0);
        chk("sweep_e5_any",   any1, 1'b1);
        a1 = 1'b0;
        tick(3);
        chk("sweep_fall_e3_level", lvl1, 1'b1);
        tick(1);
        chk("sweep_fall_e4_level", lvl1, 1'b0);
        chk("sweep_fall_e4_fall",  fall1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
